// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven hour/minute edit and load controller
// Debounces mode/up/down keys, edits hour then minute, pulses load on commit.
module time_set_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int REPEAT_DELAY    = 32768,
   parameter int REPEAT_RATE     = 8192,
   parameter int TIMEOUT         = 4194304
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_down,
   input  logic [4:0] cur_hour,
   input  logic [5:0] cur_minute,
   output logic       load,
   output logic [4:0] load_hour,
   output logic [5:0] load_minute,
   output logic [5:0] load_second,
   output logic       editing,
   output logic [1:0] edit_field,
   output logic [4:0] edit_hour,
   output logic [5:0] edit_minute
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(REPEAT_DELAY + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] REP_AT     = HW'(REPEAT_DELAY);
   localparam logic [HW-1:0] REP_RELOAD = HW'(REPEAT_DELAY - REPEAT_RATE + 1);
   localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SET_HOUR,
      S_SET_MINUTE,
      S_COMMIT
   } state_t;

   state_t state_q, state_d;

   // Key index: 0 = mode, 1 = up, 2 = down.
   logic [2:0]    raw_keys;
   logic [2:0]    sync1_q, sync1_d;
   logic [2:0]    sync2_q, sync2_d;
   logic [2:0]    deb_q, deb_d;
   logic [2:0]    deb_prev_q, deb_prev_d;
   logic [DW-1:0] db_cnt_q [3];
   logic [DW-1:0] db_cnt_d [3];
   logic [HW-1:0] hold_q [2];
   logic [HW-1:0] hold_d [2];
   logic [TW-1:0] idle_q, idle_d;
   logic [4:0]    edit_hour_q, edit_hour_d;
   logic [5:0]    edit_minute_q, edit_minute_d;

   logic [2:0] press;
   logic [1:0] rep;
   logic       mode_evt, up_evt, down_evt, any_evt, cancel, in_edit;
   logic [4:0] hour_inc, hour_dec;
   logic [5:0] min_inc, min_dec;

   assign raw_keys = {key_down, key_up, key_mode};

   always_comb begin : conditioning
      sync1_d    = raw_keys;
      sync2_d    = sync1_q;
      deb_d      = deb_q;
      deb_prev_d = deb_q;
      rep        = '0;
      for (int k = 0; k < 3; k++) begin
         db_cnt_d[k] = '0;
         if (sync2_q[k] != deb_q[k]) begin
            if (db_cnt_q[k] == DEB_LAST) begin
               deb_d[k] = ~deb_q[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
         end
      end
      press = deb_q & ~deb_prev_q;
      // Hold counter is 0 in the press cycle; after the first repeat it is
      // rewound so the next hit lands REPEAT_RATE cycles later.
      for (int r = 0; r < 2; r++) begin
         hold_d[r] = '0;
         if (deb_q[r+1]) begin
            if (hold_q[r] == REP_AT) begin
               rep[r]    = 1'b1;
               hold_d[r] = REP_RELOAD;
            end else begin
               hold_d[r] = hold_q[r] + 1'b1;
            end
         end
      end
   end

   assign mode_evt = press[0];
   assign up_evt   = press[1] | rep[0];
   assign down_evt = press[2] | rep[1];
   assign any_evt  = mode_evt | up_evt | down_evt;
   assign cancel   = up_evt & down_evt;
   assign in_edit  = (state_q == S_SET_HOUR) || (state_q == S_SET_MINUTE);

   assign hour_inc = (edit_hour_q == 5'd23) ? 5'd0 : edit_hour_q + 5'd1;
   assign hour_dec = (edit_hour_q == 5'd0) ? 5'd23 : edit_hour_q - 5'd1;
   assign min_inc  = (edit_minute_q == 6'd59) ? 6'd0 : edit_minute_q + 6'd1;
   assign min_dec  = (edit_minute_q == 6'd0) ? 6'd59 : edit_minute_q - 6'd1;

   always_comb begin : edit_fsm
      state_d       = state_q;
      edit_hour_d   = edit_hour_q;
      edit_minute_d = edit_minute_q;
      case (state_q)
         S_IDLE: begin
            if (mode_evt) begin
               state_d       = S_SET_HOUR;
               edit_hour_d   = cur_hour;
               edit_minute_d = cur_minute;
            end
         end
         S_SET_HOUR, S_SET_MINUTE: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else if (mode_evt) begin
               state_d = (state_q == S_SET_HOUR) ? S_SET_MINUTE : S_COMMIT;
            end else if (up_evt || down_evt) begin
               if (state_q == S_SET_HOUR) begin
                  edit_hour_d = up_evt ? hour_inc : hour_dec;
               end else begin
                  edit_minute_d = up_evt ? min_inc : min_dec;
               end
            end else if (idle_q == IDLE_LAST) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      idle_d = (in_edit && !any_evt && (state_d == state_q)) ? idle_q + 1'b1 : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         sync1_q       <= '0;
         sync2_q       <= '0;
         deb_q         <= '0;
         deb_prev_q    <= '0;
         idle_q        <= '0;
         edit_hour_q   <= '0;
         edit_minute_q <= '0;
         for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
         for (int r = 0; r < 2; r++) hold_q[r] <= '0;
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         deb_q         <= deb_d;
         deb_prev_q    <= deb_prev_d;
         idle_q        <= idle_d;
         edit_hour_q   <= edit_hour_d;
         edit_minute_q <= edit_minute_d;
         for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
         for (int r = 0; r < 2; r++) hold_q[r] <= hold_d[r];
      end
   end

   assign load        = (state_q == S_COMMIT);
   assign editing     = in_edit;
   assign edit_field  = (state_q == S_SET_HOUR)   ? 2'd1 :
                        (state_q == S_SET_MINUTE) ? 2'd2 : 2'd0;
   assign edit_hour   = edit_hour_q;
   assign edit_minute = edit_minute_q;
   assign load_hour   = edit_hour_q;
   assign load_minute = edit_minute_q;
   assign load_second = 6'd0;

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Button-driven time-setting controller for the clock/calendar design: the writer side of the time registers that the clock counter chain and display path read. It debounces three raw push-buttons, runs an edit state machine over hour and minute, and issues a single-cycle load of the edited time back into the hour/minute/second counters. While editing, it drives the value under edit and a field selector so the display path can show and blink it.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 1024: consecutive equal samples needed to accept a key level change (≥2).
- REPEAT_DELAY, 32768: cycles a debounced up/down key must be held before auto-repeat starts.
- REPEAT_RATE, 8192: cycles between auto-repeat events.
- TIMEOUT, 2^22: idle cycles in an edit state before the edit is abandoned.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_mode  in  1  raw mode button, active-high, asynchronous to clock.
- key_up  in  1  raw increment button, active-high, asynchronous.
- key_down  in  1  raw decrement button, active-high, asynchronous.
- cur_hour  in  5  live hour from the clock chain, 0–23.
- cur_minute  in  6  live minute from the clock chain, 0–59.
- load  out  1  one-cycle pulse: counters take load_hour/load_minute/load_second.
- load_hour  out  5  hour to load, 0–23.
- load_minute  out  6  minute to load, 0–59.
- load_second  out  6  second to load, always 0.
- editing  out  1  high in SET_HOUR and SET_MINUTE.
- edit_field  out  2  0 = none, 1 = hour, 2 = minute.
- edit_hour  out  5  hour value under edit.
- edit_minute  out  6  minute value under edit.

## Operation

- Input conditioning, per key: 2-flop synchronizer, then a debouncer holding a debounced level. A counter increments while the synchronized sample differs from the debounced level and clears when they match. When it reaches DEBOUNCE_CYCLES−1 with a differing sample, the debounced level flips and the counter clears. A press event is the cycle after the debounced level rises.
- Auto-repeat (up/down only): while the debounced level stays high, a hold counter runs. It emits an extra event REPEAT_DELAY cycles after the press event, then one every REPEAT_RATE cycles. The hold counter clears on release. Mode has no repeat.
- FSM states are IDLE, SET_HOUR, SET_MINUTE and COMMIT.
  - IDLE, mode event: capture cur_hour/cur_minute into edit_hour/edit_minute, go to SET_HOUR. Up/down events are ignored.
  - SET_HOUR: up gives edit_hour+1 (23 wraps to 0); down gives edit_hour−1 (0 wraps to 23). A mode event goes to SET_MINUTE.
  - SET_MINUTE: same as SET_HOUR but on edit_minute, with 59→0 and 0→59. A mode event goes to COMMIT.
  - COMMIT: load=1 for exactly this cycle, with load_hour=edit_hour, load_minute=edit_minute, load_second=0. Next state is IDLE.
- Cancel: up and down events in the same cycle in SET_HOUR or SET_MINUTE go to IDLE with no load and no value change.
- Priority in one cycle: cancel > mode > up/down. Mode with a single up or down: the mode transition is taken and the value is unchanged.
- Timeout: an idle counter clears on any event or state change and increments otherwise in the edit states. At TIMEOUT it goes to IDLE with no load.
- Outputs in IDLE: editing=0, edit_field=0, load=0. edit_hour/edit_minute hold their last values. load_* always mirror the edit registers.
- Arithmetic: wrap is explicit compare-and-set. Values never leave range.

## Timing

- Reset (synchronous, wins over all else): state=IDLE, synchronizers and debounced levels=0, all counters=0, load=0, editing=0, edit_field=0, edit_hour=0, edit_minute=0, load_* = 0.
- Reset mid-edit or in COMMIT: the edit is discarded, and load is 0 on the cycle after reset is sampled.
- Latency: the raw level is first sampled at edge E0. The debounced level flips at edge E0+DEBOUNCE_CYCLES+1, the event is valid in the following cycle, and the state/edit registers update at edge E0+DEBOUNCE_CYCLES+2.
- The load pulse is asserted in the cycle after the SET_MINUTE mode event is accepted.
- Raw glitches shorter than DEBOUNCE_CYCLES produce no event.
- Release also needs DEBOUNCE_CYCLES stable samples. No event is generated on release.

## Test plan

(DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=4, TIMEOUT=64.)
- Full edit: cur 10:20, then mode, up×3, mode, down×25, mode. Expect one load pulse with 13:55:00, editing returning to 0, and no other load pulses.
- Wrap: edit_hour=23 + up → 0; edit_hour=0 + down → 23; edit_minute=59 + up → 0; edit_minute=0 + down → 59.
- Debounce/repeat: a 3-cycle glitch on key_up gives no change. key_up held 40 cycles in SET_HOUR from 5 gives 1 + 1 + floor((40−debounce−16)/4) events, checked against cycle-exact expected counts.
- Cancel/timeout: up and down simultaneous in SET_MINUTE gives IDLE with load never asserted. 64 idle cycles in SET_HOUR give IDLE with no load.
- Priority: mode and up events in the same cycle in SET_HOUR go to SET_MINUTE with edit_hour unchanged.
- Reset: reset asserted in SET_MINUTE and in COMMIT gives load=0 next cycle and all outputs at their reset values.
